// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-domain side of the asynchronous FIFO.
// Synchronizes the write Gray pointer, owns the binary/Gray read pointer,
// and presents memory words through a first-word-fall-through output
// register with a valid/ready handshake.
module fifo_rd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int P_SIZE     = 4
) (
    input  logic                  R_CLK,
    input  logic                  R_RST,
    input  logic [P_SIZE-1:0]     wptr_gray,
    input  logic [DATA_WIDTH-1:0] rd_data_mem,
    output logic [P_SIZE-2:0]     raddr,
    output logic [P_SIZE-1:0]     rptr_gray,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic [P_SIZE-1:0]     rd_level
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);

    logic [P_SIZE-1:0] wq1;
    logic [P_SIZE-1:0] wq2;
    logic [P_SIZE-1:0] wq2_bin;
    logic [P_SIZE-1:0] rbin;
    logic [P_SIZE-1:0] rbin_next;
    logic              mem_empty;
    logic              load;

    // Two-flop synchronizer bringing the write Gray pointer into R_CLK.
    always_ff @(posedge R_CLK or posedge R_RST) begin
        if (R_RST) begin
            wq1 <= '0;
            wq2 <= '0;
        end else begin
            wq1 <= wptr_gray;
            wq2 <= wq1;
        end
    end

    // Gray-to-binary conversion of the synchronized write pointer, MSB first.
    always_comb begin
        wq2_bin = '0;
        wq2_bin[P_SIZE-1] = wq2[P_SIZE-1];
        for (int i = P_SIZE - 2; i >= 0; i--) begin
            wq2_bin[i] = wq2_bin[i+1] ^ wq2[i];
        end
    end

    assign rbin_next = rbin + P_SIZE'(1);
    assign raddr     = rbin[ADDR_W-1:0];

    // The wrap bit keeps equal-pointer (empty) distinct from a full memory.
    assign mem_empty = (rptr_gray == wq2);
    assign empty     = mem_empty;
    assign rd_level  = wq2_bin - rbin;

    // Refill the output register whenever it is free or being drained now.
    assign load = !mem_empty && (!rd_valid || rd_ready);

    // Read pointer and output register; accept and refill may share a cycle.
    always_ff @(posedge R_CLK or posedge R_RST) begin
        if (R_RST) begin
            rbin      <= '0;
            rptr_gray <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
        end else if (load) begin
            rd_data   <= rd_data_mem;
            rbin      <= rbin_next;
            rptr_gray <= rbin_next ^ (rbin_next >> 1);
            rd_valid  <= 1'b1;
        end else if (rd_valid && rd_ready) begin
            rd_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Testbench for fifo_rd_ctrl: models the write side (memory + Gray pointer),
// keeps a scoreboard of written words, and checks pointer/status outputs
// against a word-count model of the FIFO.
module tb_fifo_rd_ctrl;

    logic       R_CLK = 1'b0;
    logic       R_RST = 1'b0;
    logic [3:0] wptr_gray = 4'b0000;
    logic [7:0] rd_data_mem;
    logic [2:0] raddr;
    logic [3:0] rptr_gray;
    logic       rd_ready = 1'b0;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       empty;
    logic [3:0] rd_level;

    logic [7:0] mem [8];
    logic [7:0] sb [$];
    int         hist [$];
    int         checks = 0;
    int         errors = 0;
    int         wbin = 0;
    int         accepted = 0;
    bit         mon_en = 1'b0;

    fifo_rd_ctrl #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .P_SIZE(4)) dut (
        .R_CLK(R_CLK),
        .R_RST(R_RST),
        .wptr_gray(wptr_gray),
        .rd_data_mem(rd_data_mem),
        .raddr(raddr),
        .rptr_gray(rptr_gray),
        .rd_ready(rd_ready),
        .rd_valid(rd_valid),
        .rd_data(rd_data),
        .empty(empty),
        .rd_level(rd_level)
    );

    assign rd_data_mem = mem[raddr];

    always #5 R_CLK = ~R_CLK;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] gray4(input int b);
        logic [3:0] v;
        v = b[3:0];
        return v ^ (v >> 1);
    endfunction

    function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic tick();
        @(posedge R_CLK);
        #1;
    endtask

    task automatic clear_model();
        wbin      = 0;
        accepted  = 0;
        wptr_gray = 4'b0000;
        sb.delete();
        hist.delete();
    endtask

    task automatic do_reset();
        tick();
        R_RST    = 1'b1;
        rd_ready = 1'b0;
        clear_model();
        tick();
        tick();
        R_RST = 1'b0;
    endtask

    task automatic write_word(input logic [7:0] d);
        mem[wbin[2:0]] = d;
        sb.push_back(d);
        wbin++;
        wptr_gray = gray4(wbin);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_rd_level"}, rd_level, 0);
        chk({tag, "_raddr"}, raddr, 0);
        chk({tag, "_rptr_gray"}, rptr_gray, 0);
    endtask

    task automatic drain();
        int n;
        rd_ready = 1'b1;
        repeat (3) tick();
        n = 0;
        while (!(rd_valid == 1'b0 && empty == 1'b1 && rd_level == 4'd0) && n < 60) begin
            tick();
            n++;
        end
        chk("drain_done", n < 60, 1);
    endtask

    // Write-pointer history at each R_CLK edge; the synchronizer output lags two edges.
    always @(posedge R_CLK) begin
        if (R_RST) hist.delete();
        else hist.push_back(wbin);
    end

    // Monitor: pointer/status vs. word-count model, and scoreboard on each accept.
    always @(negedge R_CLK) begin
        int         loaded;
        int         h;
        logic [3:0] wq;
        logic [3:0] lvl;
        if (mon_en && !R_RST) begin
            loaded = accepted + (rd_valid ? 1 : 0);
            if (hist.size() >= 2) begin
                h  = hist[hist.size()-2];
                wq = h[3:0];
            end else begin
                wq = 4'd0;
            end
            lvl = wq - loaded[3:0];
            chk("mon_rd_level", rd_level, lvl);
            chk("mon_empty", empty, lvl == 4'd0);
            chk("mon_raddr", raddr, loaded[2:0]);
            chk("mon_rptr_gray", rptr_gray, gray4(loaded));
            if (rd_valid && rd_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon_unexpected_word actual=%0h expected=none at %0t", rd_data, $time);
                end else begin
                    chk("mon_rd_data", rd_data, sb.pop_front());
                end
                accepted++;
            end
        end
    end

    initial begin
        // Reset values, asserted between clock edges with the write pointer moving.
        #1;
        R_RST     = 1'b1;
        wptr_gray = 4'b0011;
        #1;
        check_reset_outputs("rst_noedge");
        tick();
        wptr_gray = 4'b0000;
        tick();
        wptr_gray = 4'b0011;
        tick();
        check_reset_outputs("rst_held");
        wptr_gray = 4'b0000;
        clear_model();
        R_RST  = 1'b0;
        mon_en = 1'b1;

        // Single word with first-word latency.
        do_reset();
        write_word(8'hA5);
        tick();
        tick();
        chk("sw_level", rd_level, 1);
        chk("sw_empty", empty, 0);
        chk("sw_valid_early", rd_valid, 0);
        tick();
        chk("sw_valid", rd_valid, 1);
        chk("sw_data", rd_data, 8'hA5);
        chk("sw_raddr", raddr, 1);
        chk("sw_rptr", rptr_gray, 4'b0001);
        chk("sw_empty_after", empty, 1);
        chk("sw_level_after", rd_level, 0);
        rd_ready = 1'b1;
        tick();
        chk("sw_valid_drop", rd_valid, 0);
        rd_ready = 1'b0;

        // Back-pressure with three pending words.
        do_reset();
        write_word(8'h11);
        write_word(8'h22);
        write_word(8'h33);
        repeat (13) tick();
        chk("bp_data", rd_data, 8'h11);
        chk("bp_valid", rd_valid, 1);
        chk("bp_raddr", raddr, 1);
        chk("bp_level", rd_level, 2);
        rd_ready = 1'b1;
        tick();
        chk("bp_data2", rd_data, 8'h22);
        chk("bp_valid2", rd_valid, 1);
        tick();
        chk("bp_data3", rd_data, 8'h33);
        chk("bp_valid3", rd_valid, 1);
        tick();
        chk("bp_valid_end", rd_valid, 0);
        rd_ready = 1'b0;

        // Full memory drained at one word per cycle.
        do_reset();
        for (int i = 0; i < 8; i++) write_word(8'(8'h40 + i * 3));
        tick();
        tick();
        chk("fd_level", rd_level, 8);
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("fd_valid", rd_valid, 1);
            chk("fd_data", rd_data, 8'(8'h40 + i * 3));
        end
        chk("fd_rptr", rptr_gray, 4'b1100);
        chk("fd_empty", empty, 1);
        tick();
        chk("fd_valid_end", rd_valid, 0);
        rd_ready = 1'b0;

        // Wrap-around after 14 reads of history.
        do_reset();
        for (int i = 0; i < 7; i++) write_word(8'(i + 1));
        drain();
        for (int i = 0; i < 7; i++) write_word(8'(i + 8));
        drain();
        chk("wr_raddr_start", raddr, 6);
        chk("wr_rptr_start", rptr_gray, 4'b1001);
        for (int i = 0; i < 4; i++) write_word(8'(8'hC0 + i));
        tick();
        tick();
        chk("wr_raddr_pre", raddr, 6);
        chk("wr_empty_pre", empty, 0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("wr_raddr", raddr, (6 + k) % 8);
            chk("wr_rptr", rptr_gray, gray4(14 + k));
            chk("wr_empty", empty, k == 4);
            chk("wr_valid", rd_valid, 1);
        end
        drain();
        rd_ready = 1'b0;

        // Reset pulse mid-stream while a word is held.
        do_reset();
        for (int i = 0; i < 5; i++) write_word(8'(8'h90 + i));
        tick();
        tick();
        tick();
        chk("ms_valid", rd_valid, 1);
        #2;
        R_RST = 1'b1;
        clear_model();
        #1;
        check_reset_outputs("ms_rst");
        R_RST    = 1'b0;
        rd_ready = 1'b1;
        repeat (5) begin
            tick();
            chk("ms_no_word", rd_valid, 0);
        end
        rd_ready = 1'b0;

        // Randomized traffic against the scoreboard and word-count model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            int n;
            rd_ready = ($urandom_range(0, 3) != 0);
            n = $urandom_range(0, 2);
            for (int j = 0; j < n; j++) begin
                if (wbin - accepted < 8) write_word(8'($urandom));
            end
            tick();
        end
        drain();
        chk("rand_sb_empty", sb.size(), 0);
        chk("rand_all_read", accepted, wbin);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side controller for the asynchronous FIFO, sitting in the read clock domain opposite the write-side memory and pointer logic. It synchronizes the write Gray pointer into `R_CLK`, maintains the binary/Gray read pointer, drives the memory read address, and presents data through a first-word-fall-through output register with a valid/ready handshake. It also exports the read Gray pointer for the write domain's full-flag logic, plus empty and occupancy status.

## Interface
- `DATA_WIDTH`, default 8: word width.
- `FIFO_DEPTH`, default 8: number of memory entries; a power of two.
- `P_SIZE`, default 4: pointer width, log2(`FIFO_DEPTH`)+1. The extra MSB is the wrap bit.
- `R_CLK`  in  1: read-domain clock. All flops use the rising edge.
- `R_RST`  in  1: asynchronous, active-high reset.
- `wptr_gray`  in  `P_SIZE`: write pointer in Gray code, asynchronous to `R_CLK`.
- `rd_data_mem`  in  `DATA_WIDTH`: combinational memory read data at `raddr`.
- `raddr`  out  `P_SIZE-1`: memory read address, equal to `rbin[P_SIZE-2:0]`.
- `rptr_gray`  out  `P_SIZE`: registered read pointer in Gray code, sent to the write domain.
- `rd_ready`  in  1: consumer accepts `rd_data` this cycle.
- `rd_valid`  out  1: `rd_data` holds a valid word.
- `rd_data`  out  `DATA_WIDTH`: output register.
- `empty`  out  1: no unread words remain in memory. A word may still be held in `rd_data`.
- `rd_level`  out  `P_SIZE`: number of unread words in memory.

## Operation
- **Synchronizer:** two-flop chain `wq1`, `wq2` samples `wptr_gray`. `wq2` is converted combinationally to binary `wq2_bin` (iterative XOR from the MSB down).
- **Read pointer:**
  - Binary `rbin` is `P_SIZE` bits and wraps modulo 2^`P_SIZE`.
  - `rptr_gray` is registered and updated on the same edge as `rbin`, with `rptr_gray = rbin_next ^ (rbin_next >> 1)`.
  - Only one bit of `rptr_gray` changes per increment.
- **Memory-empty:** `mem_empty = (rptr_gray == wq2)`. The `empty` output equals `mem_empty`.
- **Occupancy:** `rd_level = wq2_bin - rbin`, modulo 2^`P_SIZE`. Range is 0..`FIFO_DEPTH`.
- **Load condition:** `load = !mem_empty && (!rd_valid || rd_ready)`.
- **Register updates:**
  - On `load`: `rd_data <= rd_data_mem`, `rbin <= rbin + 1`, `rd_valid <= 1`.
  - On `rd_valid && rd_ready && !load`: `rd_valid <= 0`, and `rd_data` holds its last value.
  - Otherwise all registers hold.
- **Back-pressure:** while `rd_valid=1` and `rd_ready=0`, `rd_data`, `rd_valid`, `rbin` and `raddr` are frozen. No word is lost or skipped.
- **Simultaneous accept and refill:** accept and load happen in the same cycle. `rd_valid` stays 1 and `rd_data` takes the next word. Sustained throughput is one word per `R_CLK`.
- **Wrap-around:**
  - `rbin` goes from 2^`P_SIZE`-1 to 0, and `raddr` goes from `FIFO_DEPTH`-1 to 0.
  - `mem_empty` and `rd_level` remain correct across the wrap, because the wrap bit distinguishes full from empty.
- **Write pointer movement:** a write pointer advancing by several words between samples is tolerated. Each `wq2` sample is a valid Gray code value, and the level jumps accordingly.
- **Reset:**
  - `R_RST` high clears `wq1`, `wq2`, `rbin`, `rptr_gray`, `rd_data` and `rd_valid` to 0 immediately, regardless of `R_CLK`.
  - Reset values: `raddr=0`, `rptr_gray=0`, `rd_valid=0`, `rd_data=0`, `empty=1`, `rd_level=0`.
  - Reset mid-operation discards any held word. The write domain is reset together with this block, at system level.
- **Release:** `R_RST` deasserts synchronously to `R_CLK` at system level.

## Timing
- **Synchronizer latency:** `wptr_gray` stable before R_CLK edge N gives:
  - `wq2` updated after edge N+1.
  - `empty` and `rd_level` reflect the new value after edge N+1.
- **First-word latency:** `rd_valid` rises after edge N+2, when `rd_valid` was 0. Latency is 3 `R_CLK` edges from write pointer to valid data.
- **Read pointer visibility:** `rptr_gray` changes on the same edge that loads the word. The write domain sees the change after its own 2-flop synchronizer.
- **Status signals:** `rd_level` and `empty` are combinational from registered state only. They have no input-to-output combinational path.
- **Memory read path:** `raddr` is registered. `rd_data_mem` must settle within one `R_CLK` period.

## Test plan
- **Reset values:** assert `R_RST` with `wptr_gray=4'b0011` toggling -> `rd_valid=0`, `rd_data=0`, `empty=1`, `rd_level=0`, `raddr=0`, `rptr_gray=0`. Outputs are cleared without any `R_CLK` edge.
- **Single word:** set `wptr_gray` from 0000 to 0001 with memory[0]=8'hA5 and `rd_ready=0` ->
  - `rd_level=1` and `empty=0` after 2 edges.
  - After 3 edges: `rd_valid=1`, `rd_data=A5`, `raddr=1`, `rptr_gray=0001`, `empty=1`, `rd_level=0`.
  - `rd_ready=1` for one cycle -> `rd_valid=0` on the next edge.
- **Back-pressure:** 3 words (11,22,33) pending, `rd_ready=0` for 10 cycles ->
  - `rd_data=11` is held, `raddr=1`, `rd_level=2`.
  - Then `rd_ready=1` -> 22 and 33 appear on consecutive cycles, followed by `rd_valid=0`.
- **Full drain:** 8 words written (`wptr_gray=1100`, bin 8), `rd_level=8` -> `rd_ready=1` steady delivers all 8 words in order on 8 consecutive cycles. Final `rptr_gray=1100` and `empty=1`.
- **Wrap-around:** preload `rbin=14` (via a traffic history of 14 reads), then write 4 more words -> `raddr` sequence 6,7,0,1. `rptr_gray` goes through 1001, 1000, 0000, 0001. No spurious `empty` occurs during the wrap.
- **Reset mid-stream:** 5 words pending, `rd_valid=1`, then pulse `R_RST` for 1 ns mid-cycle -> all outputs return to reset values immediately. No word is delivered afterwards until `wptr_gray` advances again.
